tile_sequencer: RTL

Frame-level scheduler for the tile-drawing datapath. It walks a COLS×ROWS bitmap in raster order. For each cell it reads one bit from the bitmap memory, hands that bit to the per-cell draw controller with a start pulse, and waits for the controller's finish flag before moving to the next cell. It sits between the VGA frame timing (which supplies frame_start) and the per-cell draw/black controller.

---
 rtl/tile_sequencer_if.sv | 30 +++
 rtl/tile_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/tile_sequencer_if.sv
// Bundles the bitmap-read, cell-controller and status signals of tile_sequencer.
// master = the sequencer, slave = frame timing / bitmap memory / cell controller.
interface tile_sequencer_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned CW = 3,
  parameter int unsigned RW = 3
);
  logic          frame_start;
  logic          bm_rd;
  logic [AW-1:0] bm_addr;
  logic          bm_data;
  logic          cell_start;
  logic          cell_bit;
  logic          cell_done;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  modport master (
    input  frame_start, bm_data, cell_done,
    output bm_rd, bm_addr, cell_start, cell_bit, col, row, busy, frame_done, overrun
  );

  modport slave (
    output frame_start, bm_data, cell_done,
    input  bm_rd, bm_addr, cell_start, cell_bit, col, row, busy, frame_done, overrun
  );
endinterface

// File: rtl/tile_sequencer.sv
// Raster-order frame scheduler: fetches one bitmap bit per cell, starts the cell
// controller with it and waits for cell_done before advancing.
module tile_sequencer #(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 6,
  parameter int unsigned AW   = 6,
  parameter int unsigned CW   = 3,
  parameter int unsigned RW   = 3
) (
  input logic               clk,
  input logic               reset,
  tile_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StStart,
    StDraw,
    StNext
  } state_e;

  localparam logic [CW-1:0] LastCol = CW'(COLS - 1);
  localparam logic [RW-1:0] LastRow = RW'(ROWS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          cell_bit_q, cell_bit_d;
  logic          overrun_q, overrun_d;
  logic          last_col, last_cell;

  assign last_col  = (col_q == LastCol);
  assign last_cell = last_col && (row_q == LastRow);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = bus.frame_start ? StFetch : StIdle;
      StFetch: state_d = StLatch;
      StLatch: state_d = StStart;
      StStart: state_d = StDraw;
      StDraw:  state_d = bus.cell_done ? StNext : StDraw;
      StNext:  state_d = last_cell ? StIdle : StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.bm_rd      = 1'b0;
    bus.cell_start = 1'b0;
    bus.frame_done = 1'b0;
    bus.busy       = 1'b1;
    case (state_q)
      StIdle:  bus.busy       = 1'b0;
      StFetch: bus.bm_rd      = 1'b1;
      StStart: bus.cell_start = 1'b1;
      StNext:  bus.frame_done = last_cell;
      default: ;
    endcase
  end

  // Linear address is its own counter so bm_addr never needs row*COLS.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    idx_d      = idx_q;
    cell_bit_d = cell_bit_q;
    overrun_d  = overrun_q | (bus.frame_start && (state_q != StIdle));
    if (state_q == StLatch) begin
      cell_bit_d = bus.bm_data;
    end
    if (state_q == StNext) begin
      if (last_cell) begin
        col_d = '0;
        row_d = '0;
        idx_d = '0;
      end else if (last_col) begin
        col_d = '0;
        row_d = row_q + RW'(1);
        idx_d = idx_q + AW'(1);
      end else begin
        col_d = col_q + CW'(1);
        idx_d = idx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      idx_q      <= '0;
      cell_bit_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      idx_q      <= idx_d;
      cell_bit_q <= cell_bit_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.bm_addr  = idx_q;
  assign bus.col      = col_q;
  assign bus.row      = row_q;
  assign bus.cell_bit = cell_bit_q;
  assign bus.overrun  = overrun_q;

endmodule
